// File: rtl/instruction_loader_if.sv
// Byte-stream and instruction-memory write bus for the instruction loader.
// master = host/stream source and memory observer, slave = loader.
interface instruction_loader_if #(
  parameter int ADDR_WIDTH = 32
);
  logic                  start;
  logic [ADDR_WIDTH-1:0] base_address;
  logic [7:0]            byte_data;
  logic                  byte_valid;
  logic                  byte_last;
  logic                  byte_ready;
  logic                  mem_write_enable;
  logic [ADDR_WIDTH-1:0] mem_write_address;
  logic [31:0]           mem_write_data;
  logic [ADDR_WIDTH-1:0] words_written;
  logic                  busy;
  logic                  done;
  logic                  error;

  modport master (
    output start, base_address, byte_data, byte_valid, byte_last,
    input  byte_ready, mem_write_enable, mem_write_address, mem_write_data,
           words_written, busy, done, error
  );

  modport slave (
    input  start, base_address, byte_data, byte_valid, byte_last,
    output byte_ready, mem_write_enable, mem_write_address, mem_write_data,
           words_written, busy, done, error
  );
endinterface

// File: rtl/instruction_loader.sv
// Packs a big-endian byte stream into 32-bit instructions and writes them
// to consecutive instruction-memory words; busy holds the core off meanwhile.
module instruction_loader #(
  parameter int NUM_WORDS  = 6,
  parameter int ADDR_WIDTH = 32
) (
  input  logic clk,
  input  logic rst_n,
  instruction_loader_if.slave bus
);
  typedef enum logic [1:0] {IDLE, RECEIVE, WRITE, DONE} state_t;

  state_t                state;
  logic [ADDR_WIDTH-1:0] addr;
  logic [1:0]            byte_index;
  logic [23:0]           word;       // first three bytes; the fourth goes straight to the write data
  logic                  last_flag;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state                 <= IDLE;
      addr                  <= '0;
      byte_index            <= '0;
      word                  <= '0;
      last_flag             <= 1'b0;
      bus.byte_ready        <= 1'b0;
      bus.mem_write_enable  <= 1'b0;
      bus.mem_write_address <= '0;
      bus.mem_write_data    <= '0;
      bus.words_written     <= '0;
      bus.busy              <= 1'b0;
      bus.done              <= 1'b0;
      bus.error             <= 1'b0;
    end else begin
      bus.mem_write_enable <= 1'b0;
      case (state)
        IDLE, DONE: begin
          if (bus.start) begin
            state             <= RECEIVE;
            addr              <= bus.base_address;
            byte_index        <= '0;
            last_flag         <= 1'b0;
            bus.words_written <= '0;
            bus.done          <= 1'b0;
            bus.error         <= 1'b0;
            bus.byte_ready    <= 1'b1;
            bus.busy          <= 1'b1;
          end
        end
        RECEIVE: begin
          // byte_ready is always high in this state, so valid alone means accept
          if (bus.byte_valid) begin
            word       <= {word[15:0], bus.byte_data};
            byte_index <= byte_index + 2'd1;
            if (byte_index == 2'd3) begin
              last_flag             <= bus.byte_last;
              state                 <= WRITE;
              bus.byte_ready        <= 1'b0;
              bus.mem_write_enable  <= 1'b1;
              bus.mem_write_address <= addr;
              bus.mem_write_data    <= {word, bus.byte_data};
            end else if (bus.byte_last) begin
              state          <= DONE;
              bus.error      <= 1'b1;
              bus.done       <= 1'b1;
              bus.busy       <= 1'b0;
              bus.byte_ready <= 1'b0;
            end
          end
        end
        WRITE: begin
          addr              <= addr + ADDR_WIDTH'(1);
          bus.words_written <= bus.words_written + ADDR_WIDTH'(1);
          byte_index        <= '0;
          if (last_flag ||
              (bus.words_written + ADDR_WIDTH'(1) == ADDR_WIDTH'(NUM_WORDS))) begin
            state    <= DONE;
            bus.done <= 1'b1;
            bus.busy <= 1'b0;
          end else begin
            state          <= RECEIVE;
            bus.byte_ready <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: doc/instruction_loader.md
Name: instruction_loader

Overview:
- Writer side of the instruction memory.
- Accepts a byte stream (e.g. from a UART or testbench host), packs each group of 4 bytes into one 32-bit uPower instruction (MSB first), and writes it to consecutive word addresses of the instruction memory.
- The fetch side indexes that memory by program counter.
- `busy` holds the core off until loading completes.

Parameters:
- NUM_WORDS, 6: maximum instructions per load; load terminates after this many writes.
- ADDR_WIDTH, 32: width of word address and word counter.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous, active-low reset
- start  in  1  one-cycle pulse; begins a load
- base_address  in  ADDR_WIDTH  first word address, sampled on accepted start
- byte_data  in  8  stream byte
- byte_valid  in  1  byte_data valid
- byte_last  in  1  qualifies final byte of final instruction
- byte_ready  out  1  loader can accept a byte
- mem_write_enable  out  1  one-cycle write strobe
- mem_write_address  out  ADDR_WIDTH  word index written
- mem_write_data  out  32  assembled instruction
- words_written  out  ADDR_WIDTH  instructions written in current/last load
- busy  out  1  load in progress
- done  out  1  sticky; load finished
- error  out  1  sticky; stream ended mid-word

Behaviour:
- Clock and reset: one clock. Reset is asynchronous, active-low on rst_n.
- Reset state:
  - FSM in IDLE.
  - All outputs 0: byte_ready, mem_write_enable, mem_write_address, mem_write_data, words_written, busy, done, error.
  - Internal byte_index, word shift register and last flag are 0.
- Reset mid-operation: partial word discarded, no write issued. Completed writes are not undone.
- States: IDLE, RECEIVE, WRITE, DONE.
- IDLE:
  - byte_ready=0, busy=0.
  - start=1: go to RECEIVE. Load address<=base_address; byte_index, words_written, last flag <=0; done, error <=0.
- RECEIVE:
  - byte_ready=1, busy=1.
  - A byte is accepted when byte_valid&&byte_ready.
  - On accept: word<={word[23:0],byte_data}, byte_index++.
  - Accept with byte_index==3: capture byte_last into last flag; go to WRITE.
  - Accept with byte_last=1 and byte_index!=3: error<=1, go to DONE, no write.
  - No accept: hold state.
- WRITE (exactly one cycle):
  - mem_write_enable=1, mem_write_address=current address, mem_write_data=assembled word; byte_ready=0.
  - Next edge: address++ (wraps modulo 2^ADDR_WIDTH), words_written++, byte_index<=0.
  - If last flag set or words_written+1==NUM_WORDS: go to DONE. Otherwise go to RECEIVE.
- DONE:
  - done=1, busy=0, byte_ready=0; mem_write_address holds last value.
  - start=1: restart exactly as from IDLE.
- start while busy (RECEIVE/WRITE) is ignored.
- Bytes offered while byte_ready=0 are not consumed; the source must hold them.
- Latency: write strobe in the cycle immediately after the 4th byte is accepted. Peak throughput is 4 bytes per 5 cycles.
- Byte order: first byte received = instruction bits [31:24]. This is big-endian, the uPower instruction order.
- mem_write_enable is high only in WRITE, never two consecutive cycles.
- words_written never exceeds NUM_WORDS.
- byte_last on a non-accepted cycle has no effect.

Test Plan:
1. Reset, start with base_address=0, stream 24 bytes of 6 instructions (first 0x7C221A14), byte_last on byte 24 -> six write strobes at addresses 0..5, word 0 = 0x7C221A14; done=1, words_written=6, error=0.
2. NUM_WORDS=6, stream 32 bytes with no byte_last -> exactly 6 writes, then byte_ready=0 and done=1; bytes 25..32 not accepted.
3. Start with base_address=3, 8 bytes, byte_last on byte 8, byte_valid randomly deasserted -> writes to addresses 3 and 4 only, data unaffected by stalls; words_written=2.
4. byte_last on the 6th byte (mid-word 2) -> one write only (address base), error=1, done=1, no second strobe.
5. Assert rst_n=0 asynchronously after 2 bytes of word 1 -> all outputs 0 immediately, no write. A new start then loads cleanly from base_address.
6. Pulse start during RECEIVE, then restart from DONE with base_address=0xFFFFFFFF and 8 bytes -> mid-load start ignored; restart clears done/error/words_written, writes addresses 0xFFFFFFFF then 0x00000000.
